// File: rtl/loader_pkg.sv
// loader_pkg: command bytes, FSM states and memory size defaults shared by mem_loader.
// The S_CSUM state only exists when LOADER_CHECKSUM_EN is defined.
package loader_pkg;
  localparam logic [7:0] CMD_LOAD_IM = 8'hA5;
  localparam logic [7:0] CMD_LOAD_DM = 8'h5A;
  localparam logic [7:0] CMD_RUN = 8'hC3;
  localparam logic [7:0] CMD_HALT = 8'hF0;
  localparam int INSTR_MEM_SIZE_DEF = 1024;
  localparam int DATA_MEM_SIZE_DEF = 1024;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA, S_RUN
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } loader_state_t;
endpackage

// File: rtl/mem_loader.sv
// mem_loader: byte-stream loader for instruction/data memories; holds the CPU in reset until RUN.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on every load frame.
module mem_loader
  import loader_pkg::*;
#(
  parameter int INSTR_MEM_SIZE = INSTR_MEM_SIZE_DEF,
  parameter int DATA_MEM_SIZE = DATA_MEM_SIZE_DEF,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic              dm_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              err
);
  localparam logic [ADDR_W:0] IM_LIM = (ADDR_W+1)'(INSTR_MEM_SIZE);
  localparam logic [ADDR_W:0] DM_LIM = (ADDR_W+1)'(DATA_MEM_SIZE);
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t S_END = S_CSUM;
`else
  localparam loader_state_t S_END = S_IDLE;
`endif
  loader_state_t r_state, w_state_n;
  logic              r_rx_ready, r_in_vld, r_is_dm, w_is_dm_n;
  logic [7:0]        r_in_data, r_mem_wdata;
  logic [ADDR_W-1:0] r_addr, w_addr_n, r_len, w_len_n, w_len_lo, r_mem_addr;
  logic              r_err, w_err_n, w_we_n, w_in_range;
  logic              r_im_we, r_dm_we, r_cpu_rst_n, r_busy;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum, w_csum_n;
`endif
  assign w_in_range = r_is_dm ? ({1'b0, r_addr} < DM_LIM) : ({1'b0, r_addr} < IM_LIM);
  assign w_len_lo = {r_len[ADDR_W-9:0], r_in_data};
  // Incoming bytes are registered first; the FSM acts on r_in_data one cycle after acceptance.
  always_comb begin
    w_state_n = r_state;
    w_is_dm_n = r_is_dm;
    w_addr_n = r_addr;
    w_len_n = r_len;
    w_err_n = r_err;
    w_we_n = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    w_csum_n = r_csum;
`endif
    if (r_in_vld)
      case (r_state)
        S_IDLE: begin
          if (r_in_data == CMD_LOAD_IM || r_in_data == CMD_LOAD_DM) begin
            w_state_n = S_ADDR_HI;
            w_is_dm_n = (r_in_data == CMD_LOAD_DM);
          end else if (r_in_data == CMD_RUN) w_state_n = S_RUN;
          else w_err_n = 1'b1;
        end
        S_ADDR_HI: begin
          w_addr_n = ADDR_W'(r_in_data);
          w_state_n = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          w_addr_n = {r_addr[ADDR_W-9:0], r_in_data};
          w_state_n = S_LEN_HI;
        end
        S_LEN_HI: begin
          w_len_n = ADDR_W'(r_in_data);
          w_state_n = S_LEN_LO;
        end
        S_LEN_LO: begin
          w_len_n = w_len_lo;
          w_state_n = (w_len_lo == '0) ? S_END : S_DATA;
`ifdef LOADER_CHECKSUM_EN
          w_csum_n = 8'h00;
`endif
        end
        S_DATA: begin
          w_we_n = 1'b1;
          w_err_n = r_err | ~w_in_range;
          w_addr_n = r_addr + ADDR_W'(1);
          w_len_n = r_len - ADDR_W'(1);
          w_state_n = (r_len == ADDR_W'(1)) ? S_END : S_DATA;
`ifdef LOADER_CHECKSUM_EN
          w_csum_n = r_csum ^ r_in_data;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          w_err_n = r_err | (r_in_data != r_csum);
          w_state_n = S_IDLE;
        end
`endif
        S_RUN: w_state_n = (r_in_data == CMD_HALT) ? S_IDLE : S_RUN;
        default: w_state_n = S_IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rx_ready <= 1'b0;
      r_in_vld <= 1'b0;
      r_in_data <= '0;
      r_is_dm <= 1'b0;
      r_addr <= '0;
      r_len <= '0;
      r_err <= 1'b0;
      r_im_we <= 1'b0;
      r_dm_we <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wdata <= '0;
      r_cpu_rst_n <= 1'b0;
      r_busy <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_rx_ready <= 1'b1;
      r_in_vld <= rx_valid & r_rx_ready;
      r_in_data <= rx_data;
      r_is_dm <= w_is_dm_n;
      r_addr <= w_addr_n;
      r_len <= w_len_n;
      r_err <= w_err_n;
      r_im_we <= w_we_n & w_in_range & ~r_is_dm;
      r_dm_we <= w_we_n & w_in_range & r_is_dm;
      r_mem_addr <= w_we_n ? r_addr : r_mem_addr;
      r_mem_wdata <= w_we_n ? r_in_data : r_mem_wdata;
      r_cpu_rst_n <= (w_state_n == S_RUN);
      r_busy <= (w_state_n != S_IDLE) && (w_state_n != S_RUN);
`ifdef LOADER_CHECKSUM_EN
      r_csum <= w_csum_n;
`endif
    end
  end
  assign rx_ready = r_rx_ready;
  assign im_we = r_im_we;
  assign dm_we = r_dm_we;
  assign mem_addr = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rst_n = r_cpu_rst_n;
  assign busy = r_busy;
  assign err = r_err;
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed test-plan frames plus random frames checked against a frame-level model.
module tb_mem_loader;
  logic        clk = 1'b0;
  logic        rst, rx_valid, rx_ready, im_we, dm_we, cpu_rst_n, busy, err;
  logic [7:0]  rx_data, mem_wdata;
  logic [15:0] mem_addr;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_loader dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .im_we(im_we), .dm_we(dm_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .err(err)
  );
  // model: parse the byte stream frame by frame; a byte takes effect at the step after acceptance
  logic        m_inframe = 0, m_csum_due = 0, m_dm = 0, m_run = 0, m_err = 0, m_ready = 0;
  logic [7:0]  m_h[4];
  int          m_hdr = 0;
  logic [15:0] m_addr, m_left;
  logic [7:0]  m_x;
  logic        e_im, e_dm;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata;
  logic        pend_v = 0;
  logic [7:0]  pend_d;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic end_frame();
`ifdef LOADER_CHECKSUM_EN
    m_csum_due = 1;
`else
    m_inframe = 0;
`endif
  endtask
  task automatic apply(input logic [7:0] b);
    if (m_csum_due) begin
      if (b != m_x) m_err = 1;
      m_csum_due = 0;
      m_inframe = 0;
    end else if (m_inframe && m_hdr < 4) begin
      m_h[m_hdr] = b;
      m_hdr++;
      if (m_hdr == 4) begin
        m_addr = {m_h[0], m_h[1]};
        m_left = {m_h[2], m_h[3]};
        m_x = 8'h00;
        if (m_left == 0) end_frame();
      end
    end else if (m_inframe) begin
      e_addr = m_addr;
      e_wdata = b;
      if (int'(m_addr) < 1024) begin
        if (m_dm) e_dm = 1; else e_im = 1;
      end else m_err = 1;
      m_x ^= b;
      m_addr++;
      m_left--;
      if (m_left == 0) end_frame();
    end else if (m_run) begin
      if (b == 8'hF0) m_run = 0;
    end else if (b == 8'hA5 || b == 8'h5A) begin
      m_inframe = 1;
      m_hdr = 0;
      m_dm = (b == 8'h5A);
    end else if (b == 8'hC3) m_run = 1;
    else m_err = 1;
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic acc;
    rx_valid = v;
    rx_data = d;
    rst = r;
    acc = v && m_ready && !r;
    @(negedge clk);
    e_im = 0;
    e_dm = 0;
    if (r) begin
      m_inframe = 0; m_csum_due = 0; m_run = 0; m_err = 0;
    end else if (pend_v) apply(pend_d);
    check("rx_ready", rx_ready, !r);
    check("im_we", im_we, e_im);
    check("dm_we", dm_we, e_dm);
    check("cpu_rst_n", cpu_rst_n, m_run);
    check("busy", busy, m_inframe);
    check("err", err, m_err);
    if (e_im || e_dm) begin
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
    end
    pend_v = acc;
    pend_d = d;
    m_ready = !r;
  endtask
  task automatic send(input logic [7:0] b, input logic gaps);
    if (gaps && $urandom_range(0, 3) == 0) step(0, 8'($urandom), 0);
    step(1, b, 0);
  endtask
  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i], 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask
  task automatic do_reset();
    step(0, 8'h00, 1);
    idle(1);
  endtask
  task automatic frame(input logic [7:0] cmd, input logic [15:0] a, input logic [7:0] q[$], input logic bad);
    logic [7:0] x = 8'h00;
    send(cmd, 1); send(a[15:8], 1); send(a[7:0], 1);
    send(8'(q.size() >> 8), 1); send(8'(q.size()), 1);
    foreach (q[i]) begin
      send(q[i], 1);
      x ^= q[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send(x ^ {7'd0, bad}, 1);
`endif
  endtask
  initial begin
    logic [7:0] q[$];
    logic [15:0] a;
    logic [7:0] junk[4] = '{8'h00, 8'hFF, 8'h77, 8'h12};
    rst = 1; rx_valid = 0; rx_data = 0;
    @(negedge clk);
    step(0, 8'h00, 1);
    do_reset();
    q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h04, 8'h13, 8'h00, 8'h50, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(8'h43);
`endif
    send_seq(q); idle(3);
    q = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'h55};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(8'hFF);
`endif
    send_seq(q); send(8'hC3, 0); idle(3); send(8'h42, 0); send(8'hF0, 0); idle(2);
    do_reset();
    q = '{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(8'h33);
`endif
    send_seq(q); idle(4);
    do_reset();
    send(8'h77, 0); idle(2); send(8'hC3, 0); idle(2); send(8'hF0, 0); idle(2);
    frame(8'hA5, 16'h0020, '{8'h01, 8'h02}, 0); idle(2);
    do_reset();
    send_seq('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03});
    step(0, 8'h00, 1);
    q = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h01, 8'hEE};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(8'hEE);
`endif
    send_seq(q); idle(3);
`ifdef LOADER_CHECKSUM_EN
    do_reset();
    send_seq('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h13}); idle(3);
`endif
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          q.delete();
          for (int k = $urandom_range(0, 6); k > 0; k--) q.push_back(8'($urandom));
          case ($urandom_range(0, 3))
            0: a = 16'h03FC + 16'($urandom_range(0, 3));
            1: a = 16'hFFFE;
            default: a = 16'($urandom_range(0, 1023));
          endcase
          frame($urandom_range(0, 1) ? 8'hA5 : 8'h5A, a, q, $urandom_range(0, 4) == 0);
        end
        6: begin
          send(8'hC3, 1); send(junk[$urandom_range(0, 3)], 1); idle($urandom_range(0, 2)); send(8'hF0, 1);
        end
        7: send(junk[$urandom_range(0, 3)], 1);
        8: begin
          send(8'hA5, 1); send(8'h00, 1);
          if ($urandom_range(0, 1) == 1) send(8'h00, 1);
          step(0, 8'h00, 1);
        end
        default: idle($urandom_range(1, 3));
      endcase
      if ($urandom_range(0, 15) == 0) do_reset();
    end
    idle(4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
